// File: rtl/stream_arbiter_fifo_if.sv
// Stream bundle for the round-robin merging FIFO: CHANNELS producer
// streams in, one tagged consumer stream out. The DUT takes the slave
// side and the surrounding logic takes the master side.
interface stream_arbiter_fifo_if #(
    parameter int CHANNELS   = 2,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int ID_WIDTH   = 1
);
    localparam int LEVEL_WIDTH = $clog2(DEPTH) + 1;

    logic [CHANNELS*DATA_WIDTH-1:0]  in_data;
    logic [CHANNELS-1:0]             in_valid;
    logic [CHANNELS-1:0]             in_ready;
    logic [CHANNELS*LEVEL_WIDTH-1:0] in_level;
    logic [DATA_WIDTH-1:0]           out_data;
    logic [ID_WIDTH-1:0]             out_id;
    logic                            out_valid;
    logic                            out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, in_level, out_data, out_id, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, in_level, out_data, out_id, out_valid
    );
endinterface

// File: rtl/stream_arbiter_fifo.sv
// Per-channel DEPTH-word FIFOs merged round-robin into one registered,
// id-tagged valid/ready output stream. Single clock, synchronous reset.
module stream_arbiter_fifo #(
    parameter int CHANNELS   = 2,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int ID_WIDTH   = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    stream_arbiter_fifo_if.slave  bus
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LEVEL_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem        [CHANNELS][DEPTH];
    logic [PTR_W-1:0]      wr_ptr     [CHANNELS];
    logic [PTR_W-1:0]      rd_ptr     [CHANNELS];
    logic [LEVEL_W-1:0]    count      [CHANNELS];
    logic [LEVEL_W-1:0]    count_next [CHANNELS];

    logic [CHANNELS-1:0]   in_ready_q;
    logic [CHANNELS-1:0]   wr_en;
    logic [CHANNELS-1:0]   nonempty;
    logic [CHANNELS-1:0]   sel_hot;
    logic [CHANNELS-1:0]   pop_en;
    logic [ID_WIDTH-1:0]   grant;
    logic [ID_WIDTH-1:0]   sel_id;
    logic                  sel_found;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  load;

    // Output register (stage 1 of the merged stream)
    logic [DATA_WIDTH-1:0] out_data_p1;
    logic [ID_WIDTH-1:0]   out_id_p1;
    logic                  out_vld_p1;

    assign load          = !out_vld_p1 | bus.out_ready;
    assign pop_en        = sel_hot & {CHANNELS{load}};
    assign bus.in_ready  = in_ready_q;
    assign bus.out_data  = out_data_p1;
    assign bus.out_id    = out_id_p1;
    assign bus.out_valid = out_vld_p1;

    // Per-channel handshake, occupancy and next-state word count
    always_comb begin
        bus.in_level = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            nonempty[c]   = (count[c] != '0);
            wr_en[c]      = bus.in_valid[c] & in_ready_q[c];
            count_next[c] = count[c] + LEVEL_W'(wr_en[c]) - LEVEL_W'(pop_en[c]);
            bus.in_level[c*LEVEL_W +: LEVEL_W] = count[c];
        end
    end

    // Round-robin pick: first non-empty channel after the last grant, with wrap
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        sel_hot   = '0;
        sel_data  = '0;
        for (int i = 1; i <= CHANNELS; i++) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (!sel_found && nonempty[c] && (c == (int'(grant) + i) % CHANNELS)) begin
                    sel_found  = 1'b1;
                    sel_id     = ID_WIDTH'(c);
                    sel_hot[c] = 1'b1;
                end
            end
        end
        for (int c = 0; c < CHANNELS; c++) begin
            if (sel_hot[c]) begin
                sel_data = mem[c][rd_ptr[c]];
            end
        end
    end

    // FIFO storage; contents need no reset because pointers and counts are cleared
    always_ff @(posedge clock) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (wr_en[c] && !reset) begin
                mem[c][wr_ptr[c]] <= bus.in_data[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Pointers, counts, registered ready, grant and output register
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                count[c]  <= '0;
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
            end
            in_ready_q  <= '0;
            grant       <= ID_WIDTH'(CHANNELS - 1);
            out_vld_p1  <= 1'b0;
            out_data_p1 <= '0;
            out_id_p1   <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                count[c]      <= count_next[c];
                in_ready_q[c] <= (count_next[c] < LEVEL_W'(DEPTH));
                if (wr_en[c]) begin
                    wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
                end
                if (pop_en[c]) begin
                    rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
                end
            end
            if (load) begin
                out_vld_p1 <= sel_found;
                if (sel_found) begin
                    out_data_p1 <= sel_data;
                    out_id_p1   <= sel_id;
                    grant       <= sel_id;
                end
            end
        end
    end
endmodule

// File: tb/tb_stream_arbiter_fifo.sv
// Bench for stream_arbiter_fifo (CHANNELS=2, DATA_WIDTH=8, DEPTH=4):
// queue-based reference model feeding an output scoreboard, plus
// directed scenarios for reset, latency, full, round robin and
// mid-stream reset.
module tb_stream_arbiter_fifo;
    logic clock = 1'b0;
    logic reset;

    stream_arbiter_fifo_if #(.CHANNELS(2), .DATA_WIDTH(8), .DEPTH(4), .ID_WIDTH(1)) bus ();

    stream_arbiter_fifo #(.CHANNELS(2), .DATA_WIDTH(8), .DEPTH(4), .ID_WIDTH(1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    // Reference model state
    logic [7:0] mq0[$];
    logic [7:0] mq1[$];
    logic       m_ov;
    logic [7:0] m_od;
    logic       m_oid;
    int         m_last;
    logic [1:0] m_rdy;

    logic [8:0] expq[$];   // {id, data} loaded into the output register, awaiting handshake
    logic [8:0] got_q[$];  // every completed output handshake, for directed sequence checks

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int msize(input int c);
        return (c == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic logic [7:0] mpop(input int c);
        if (c == 0) return mq0.pop_front();
        return mq1.pop_front();
    endfunction

    function automatic void mpush(input int c, input logic [7:0] d);
        if (c == 0) mq0.push_back(d);
        else mq1.push_back(d);
    endfunction

    // Reference model: each FIFO is a queue, output register refills when empty or consumed,
    // round-robin resumes after the channel served last; writes become eligible next edge.
    always @(posedge clock) begin
        if (reset) begin
            mq0.delete();
            mq1.delete();
            expq.delete();
            m_ov   = 1'b0;
            m_od   = 8'h00;
            m_oid  = 1'b0;
            m_last = 1;
            m_rdy  = 2'b00;
        end else begin
            if (!m_ov || bus.out_ready) begin
                bit found;
                found = 1'b0;
                for (int i = 1; i <= 2; i++) begin
                    int c;
                    c = (m_last + i) % 2;
                    if (!found && msize(c) > 0) begin
                        found  = 1'b1;
                        m_od   = mpop(c);
                        m_oid  = c[0];
                        m_last = c;
                    end
                end
                m_ov = found;
                if (found) expq.push_back({m_oid, m_od});
            end
            for (int c = 0; c < 2; c++) begin
                if (bus.in_valid[c] && m_rdy[c]) mpush(c, bus.in_data[c*8 +: 8]);
            end
            for (int c = 0; c < 2; c++) begin
                m_rdy[c] = (msize(c) < 4);
            end
        end
    end

    // Monitor: compare DUT against the model mid-cycle and score each output handshake
    always @(negedge clock) begin
        if (mon_en) begin
            chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
            chk("out_data", 32'(bus.out_data), 32'(m_od));
            chk("out_id", 32'(bus.out_id), 32'(m_oid));
            chk("in_ready", 32'(bus.in_ready), 32'(m_rdy));
            for (int c = 0; c < 2; c++) begin
                chk("in_level", 32'(bus.in_level[c*3 +: 3]), 32'(msize(c)));
            end
            if (bus.out_valid && bus.out_ready && !reset) begin
                if (expq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got id %0d data %0h expected no word", bus.out_id, bus.out_data);
                end else begin
                    logic [8:0] e;
                    e = expq.pop_front();
                    chk("sb_word", 32'({bus.out_id, bus.out_data}), 32'(e));
                end
                got_q.push_back({bus.out_id, bus.out_data});
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    logic [8:0] rr_exp [6];
    int k;
    bit acc;

    initial begin
        rr_exp = '{9'h001, 9'h181, 9'h002, 9'h182, 9'h003, 9'h183};
        reset         = 1'b1;
        bus.in_valid  = 2'b00;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        step();
        mon_en = 1'b1;

        // Reset held with both channels asserting valid
        bus.in_valid = 2'b11;
        bus.in_data  = 16'h5A3C;
        repeat (3) step();
        chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_out_data", 32'(bus.out_data), 32'h0);
        chk("rst_in_level", 32'(bus.in_level), 32'h0);
        reset = 1'b0;
        #3;
        chk("ready_before_edge", 32'(bus.in_ready), 32'h0);
        step();
        bus.in_valid = 2'b00;
        chk("ready_after_edge", 32'(bus.in_ready), 32'h3);

        // Latency and ordering on channel 0
        got_q.delete();
        bus.out_ready = 1'b1;
        bus.in_valid  = 2'b01;
        bus.in_data   = 16'h0011;
        step();
        chk("lat_first_edge_valid", 32'(bus.out_valid), 32'h0);
        bus.in_data = 16'h0022;
        step();
        chk("lat_second_edge_valid", 32'(bus.out_valid), 32'h1);
        chk("lat_second_edge_data", 32'(bus.out_data), 32'h11);
        bus.in_data = 16'h0033;
        step();
        bus.in_valid = 2'b00;
        repeat (4) step();
        chk("lat_count", 32'(got_q.size()), 32'd3);
        for (int i = 0; i < got_q.size() && i < 3; i++) begin
            chk("lat_seq", 32'(got_q[i]), 32'h11 * (i + 1));
        end

        // Full channel 0 under backpressure, then drain
        got_q.delete();
        bus.out_ready = 1'b0;
        bus.in_valid  = 2'b01;
        k = 0;
        repeat (8) begin
            bus.in_data = {8'h00, 8'(8'hA0 + k)};
            acc = bus.in_ready[0];
            step();
            if (acc) k++;
        end
        chk("full_accepted", 32'(k), 32'd5);
        chk("full_in_ready0", 32'(bus.in_ready[0]), 32'h0);
        chk("full_level0", 32'(bus.in_level[2:0]), 32'd4);
        chk("full_out_data", 32'(bus.out_data), 32'hA0);
        bus.out_ready = 1'b1;
        repeat (6) begin
            bus.in_valid = (k < 6) ? 2'b01 : 2'b00;
            bus.in_data  = {8'h00, 8'(8'hA0 + k)};
            acc = bus.in_ready[0] && bus.in_valid[0];
            step();
            if (acc) k++;
        end
        bus.in_valid = 2'b00;
        repeat (6) step();
        chk("full_total", 32'(k), 32'd6);
        chk("full_out_count", 32'(got_q.size()), 32'd6);
        for (int i = 0; i < got_q.size() && i < 6; i++) begin
            chk("full_seq", 32'(got_q[i]), 32'hA0 + i);
        end

        // Round robin after a fresh reset
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        step();
        got_q.delete();
        bus.out_ready = 1'b0;
        bus.in_valid  = 2'b11;
        for (int j = 0; j < 3; j++) begin
            bus.in_data = {8'(8'h81 + j), 8'(8'h01 + j)};
            step();
        end
        bus.in_valid  = 2'b00;
        bus.out_ready = 1'b1;
        repeat (8) step();
        chk("rr_count", 32'(got_q.size()), 32'd6);
        for (int i = 0; i < got_q.size() && i < 6; i++) begin
            chk("rr_seq", 32'(got_q[i]), 32'(rr_exp[i]));
        end

        // Randomized traffic, starting with the 1,0,0,1 ready pattern
        for (int n = 0; n < 400; n++) begin
            bus.in_valid  = 2'($urandom_range(0, 3));
            bus.in_data   = 16'($urandom);
            if (n < 40) bus.out_ready = (n % 4 == 0) || (n % 4 == 3);
            else        bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.in_valid  = 2'b00;
        bus.out_ready = 1'b1;
        repeat (12) step();
        chk("drain_pending", 32'(expq.size()), 32'd0);
        chk("drain_out_valid", 32'(bus.out_valid), 32'h0);

        // Reset while words are buffered and the output register is full
        got_q.delete();
        bus.out_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            bus.in_valid = (j < 3) ? 2'b11 : 2'b01;
            bus.in_data  = {8'(8'hC0 + j), 8'(8'hB0 + j)};
            step();
        end
        bus.in_valid = 2'b00;
        step();
        chk("pre_rst_levels", 32'(bus.in_level), 32'h1B);
        chk("pre_rst_out_valid", 32'(bus.out_valid), 32'h1);
        reset = 1'b1;
        step();
        chk("mid_rst_levels", 32'(bus.in_level), 32'h0);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'h0);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        repeat (6) step();
        chk("no_stale_words", 32'(got_q.size()), 32'd0);
        bus.in_valid = 2'b10;
        bus.in_data  = 16'h5A00;
        step();
        bus.in_valid = 2'b00;
        repeat (4) step();
        chk("post_rst_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) chk("post_rst_word", 32'(got_q[0]), 32'h15A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
